// File: rtl/seq_scan_ctrl.sv
// Two-requester serial pattern scanner: arbitrates a word, shifts it MSB-first
// through an overlapping "1010" Mealy detector and returns the count and position mask.
//
// ctrl state | meaning
// IDLE       | waiting for a request; grants one requester, loads its word
// SHIFT      | W cycles feeding one bit per cycle to the detector, then one commit cycle
// RESP       | result registers valid, held until the consumer accepts
//
// det state  | meaning
// S0         | no useful suffix
// S1         | suffix "1"
// S2         | suffix "10"
// S3         | suffix "101"; a 0 here completes a detection
module seq_scan_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [CW-1:0] res_count,
    output logic [W-1:0]  res_mask,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} ctrl_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    ctrl_t          r_state;
    ctrl_t          w_state_next;
    det_t           r_det;
    det_t           w_det_next;
    logic [W-1:0]   r_shift;
    logic [CW-1:0]  r_bitcnt;
    logic [W-1:0]   r_acc_mask;
    logic [CW-1:0]  r_acc_count;
    logic           r_id;
    logic           r_last;
    logic           r_res_valid;
    logic           r_res_id;
    logic [CW-1:0]  r_res_count;
    logic [W-1:0]   r_res_mask;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_bit;
    logic           w_detect;
    logic           w_shift_done;

    // r_last = 1 means req1 was granted last, so req0 wins the next tie
    assign w_grant0     = (r_state == IDLE) && !reset && req0_valid && (!req1_valid || r_last);
    assign w_grant1     = (r_state == IDLE) && !reset && req1_valid && (!req0_valid || !r_last);
    assign w_bit        = r_shift[W-1];
    assign w_shift_done = (r_bitcnt == CW'(W));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_count  = r_res_count;
    assign res_mask   = r_res_mask;
    assign busy       = (r_state != IDLE);

    always_comb begin
        w_det_next = r_det;
        w_detect   = 1'b0;
        case (r_det)
            S0: w_det_next = w_bit ? S1 : S0;
            S1: w_det_next = w_bit ? S1 : S2;
            S2: w_det_next = w_bit ? S3 : S0;
            S3: begin
                w_det_next = w_bit ? S1 : S2;
                w_detect   = !w_bit;
            end
            default: w_det_next = S0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_state_next = SHIFT;
            SHIFT:   if (w_shift_done) w_state_next = RESP;
            RESP:    if (res_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_det       <= S0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_acc_mask  <= '0;
            r_acc_count <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_count <= '0;
            r_res_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_shift     <= w_grant1 ? req1_data : req0_data;
                        r_id        <= w_grant1;
                        r_last      <= w_grant1;
                        r_det       <= S0;
                        r_bitcnt    <= '0;
                        r_acc_mask  <= '0;
                        r_acc_count <= '0;
                    end
                end
                SHIFT: begin
                    if (!w_shift_done) begin
                        r_det       <= w_det_next;
                        r_shift     <= r_shift << 1;
                        // shifting the mask in from the LSB lands serial bit i at W-1-i
                        r_acc_mask  <= {r_acc_mask[W-2:0], w_detect};
                        r_acc_count <= r_acc_count + {{(CW-1){1'b0}}, w_detect};
                        r_bitcnt    <= r_bitcnt + CW'(1);
                    end else begin
                        r_res_valid <= 1'b1;
                        r_res_id    <= r_id;
                        r_res_count <= r_acc_count;
                        r_res_mask  <= r_acc_mask;
                    end
                end
                RESP: begin
                    if (res_ready) r_res_valid <= 1'b0;
                end
                default: r_res_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized and directed bench for seq_scan_ctrl against a window-matching
// reference of the 1010 scan and a transaction-level arbitration model.
module tb_seq_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          res_valid, res_ready, res_id;
    logic [CW-1:0] res_count;
    logic [W-1:0]  res_mask;
    logic          busy;

    seq_scan_ctrl #(.W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_mask(res_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a detection is any 4-bit window inside the word equal to 1010
    function automatic void ref_scan(input logic [W-1:0] d, output int cnt, output logic [W-1:0] m);
        logic [3:0] win;
        win = '0;
        cnt = 0;
        m   = '0;
        for (int i = 0; i < W; i++) begin
            win = {win[2:0], d[W-1-i]};
            if (i >= 3 && win == 4'b1010) begin
                cnt++;
                m[W-1-i] = 1'b1;
            end
        end
    endfunction

    // Transaction model: one job in flight, result visible W+1 edges after accept
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    bit           j_id;
    logic [W-1:0] j_data;
    int           j_acc;
    bit           glog[$];

    always @(negedge clk) begin
        bit           g0, g1, exp_v;
        int           ec;
        logic [W-1:0] em;
        if (reset) begin
            check_eq("rst_req0_ready", req0_ready, 0);
            check_eq("rst_req1_ready", req1_ready, 0);
            check_eq("rst_res_valid", res_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_res_id", res_id, 0);
            check_eq("rst_res_count", res_count, 0);
            check_eq("rst_res_mask", res_mask, 0);
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            g0 = !m_busy && req0_valid && (!req1_valid || m_last);
            g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            check_eq("busy", busy, m_busy);
            check_eq("req0_ready", req0_ready, g0);
            check_eq("req1_ready", req1_ready, g1);
            exp_v = m_busy && (cyc >= j_acc + W + 1);
            check_eq("res_valid", res_valid, exp_v);
            if (exp_v) begin
                ref_scan(j_data, ec, em);
                check_eq("res_id", res_id, j_id);
                check_eq("res_count", res_count, ec);
                check_eq("res_mask", res_mask, em);
                if (res_ready) m_busy = 1'b0;
            end
            if (g0 || g1) begin
                j_id   = g1;
                j_data = g1 ? req1_data : req0_data;
                j_acc  = cyc + 1;
                m_last = g1;
                m_busy = 1'b1;
                glog.push_back(g1);
            end
        end
    end

    task automatic start_job(input bit id, input logic [W-1:0] d);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("tmo_ready", 0, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_res(input bit eid, input logic [W-1:0] em, input int ec);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        if (ok) begin
            check_eq("dir_res_id", res_id, eid);
            check_eq("dir_res_mask", res_mask, em);
            check_eq("dir_res_count", res_count, ec);
        end else begin
            check_eq("tmo_res_valid", 0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        start_job(0, 8'hAA); wait_res(0, 8'h15, 3);
        start_job(1, 8'h5A); wait_res(1, 8'h01, 1);
        start_job(1, 8'hA0); wait_res(1, 8'h10, 1);
        start_job(0, 8'h05); wait_res(0, 8'h00, 0);
        start_job(0, 8'h00); wait_res(0, 8'h00, 0);

        // both requesters valid continuously after reset
        pulse_reset();
        glog.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'h3C; req1_data = 8'hC3;
        repeat (4 * (W + 3) + 4) @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("arb_num_grants", (glog.size() >= 4), 1);
        if (glog.size() >= 4) begin
            check_eq("arb_grant0", glog[0], 0);
            check_eq("arb_grant1", glog[1], 1);
            check_eq("arb_grant2", glog[2], 0);
            check_eq("arb_grant3", glog[3], 1);
        end
        repeat (W + 4) @(posedge clk);

        // consumer back-pressure with a competing request pending
        #1 res_ready = 1'b0;
        start_job(0, 8'hAA);
        wait_res(0, 8'h15, 3);
        req1_valid = 1'b1; req1_data = 8'h5A;
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req1_ready) begin ok = 1'b1; break; end
        end
        check_eq("hold_release_grant", ok, 1);
        check_eq("hold_release_idle", busy, 0);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_res(1, 8'h01, 1);

        // reset in the 4th SHIFT cycle aborts the job
        start_job(0, 8'hAA);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("abort_res_valid", res_valid, 0);
        check_eq("abort_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (14) @(posedge clk);
        start_job(0, 8'h0A); wait_res(0, 8'h01, 1);

        // random traffic, back-pressure and occasional reset
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = W'($urandom);
            req1_data  = W'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (W + 6) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
